registor_writer: RTL
====================

REGISTOR_WRITER -- requirements
Module: registor_writer

Interface
REQ-001 SHALL have port: clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: reset_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: phase_1  input  1  first write-phase strobe, one cycle wide.
REQ-004 SHALL have port: phase_2  input  1  second write-phase strobe, one cycle wide.
REQ-005 SHALL have port: select_1  input  4  destination code for phase_1.
REQ-006 SHALL have port: select_2  input  4  destination code for phase_2.
REQ-007 SHALL have port: registor_input  input  32  write-back data.
REQ-008 SHALL have port: eip_step_valid  input  1  instruction-advance request.
REQ-009 SHALL have port: eip_step  input  4  advance amount in bytes, 0-15.
REQ-010 SHALL have ports: eip, ebp, esp  output  32 each  registered architectural registers.
REQ-011 SHALL have port: busy  output  1  high in state P1.
REQ-012 SHALL have port: error  output  1  sticky protocol-error flag.

Function
REQ-013 Destination codes SHALL be: 1 esp<=data; 2 ebp<=data; 3 no write (immediate path); 4 esp<=esp-4 (push); 5 esp<=esp+4 (pop); 6 eip<=data; 0, 7-15 no write.
REQ-014 esp arithmetic SHALL be modulo 2^32; 0 minus 4 gives 32'hFFFF_FFFC, 32'hFFFF_FFFC plus 4 gives 0.
REQ-015 FSM states SHALL be IDLE and P1; each write SHALL appear on outputs the cycle after its strobe.
REQ-016 IDLE + phase_1: perform select_1 write, go to P1, clear timeout counter.
REQ-017 P1 + phase_2: perform select_2 write, go to IDLE.
REQ-018 IDLE + phase_2 without phase_1: no write, set error, stay IDLE.
REQ-019 phase_1 and phase_2 in the same cycle: phase_1 handled per state rules, phase_2 ignored, set error.
REQ-020 P1 + phase_1: perform select_1 write, stay P1, restart timeout, set error.
REQ-021 P1 with no strobe for 16 consecutive cycles: return to IDLE, set error; 4-bit counter.
REQ-022 error SHALL stay high until reset.
REQ-023 If phase_1 and phase_2 target the same register in different cycles, the later write SHALL win.

Reset
REQ-024 reset_n low at a clock edge SHALL set eip=0, ebp=0, esp=32'h0000_0FFC, state IDLE, counter 0, busy=0, error=0.
REQ-025 Reset SHALL override any strobe in the same cycle; a transaction in P1 is abandoned with no write.

Configuration
REQ-026 With EIP_AUTO_INC_EN defined, eip_step_valid SHALL set eip<=eip+eip_step (mod 2^32) the next cycle.
REQ-027 If a code-6 write and eip_step_valid coincide, the code-6 write SHALL win.
REQ-028 Without EIP_AUTO_INC_EN, eip_step_valid and eip_step SHALL be ignored; eip changes only by code 6 or reset.

Structure
REQ-029 Shared package registor_pkg SHALL hold select-code constants, reset constants (ESP_RESET=32'h0000_0FFC), the IDLE/P1 state type and TIMEOUT=16.
REQ-030 Sub-module registor_select_decode SHALL map a 4-bit code to one-hot write enables, used for both phases.

Verification
REQ-031 Reset, then phase_1 select_1=2 data=32'h1234 -> next cycle ebp=32'h1234, busy=1; phase_2 select_2=3 -> busy=0, ebp unchanged.
REQ-032 From reset, phase_1 select_1=4, then phase_2 select_2=4 -> esp=32'h0FF8 then 32'h0FF4; with esp=0, code 4 -> 32'hFFFF_FFFC.
REQ-033 phase_2 strobe while IDLE -> no register change, error=1 and stays 1 after 20 idle cycles.
REQ-034 phase_1 then 16 idle cycles -> busy returns 0 on the 16th, error=1; a later phase_2 does not write.
REQ-035 With EIP_AUTO_INC_EN: eip=32'h100, eip_step_valid with step=3 -> 32'h103; coincident code-6 write of 32'h200 -> eip=32'h200.
REQ-036 reset_n low while in P1 with phase_2 select_2=1 -> esp=32'h0FFC, busy=0, error=0.

Source files
------------

// File: rtl/registor_pkg.sv
// Shared definitions for the register write-back block: select codes, reset values,
// FSM state type and the per-phase write-enable bundle.
package registor_pkg;

   localparam logic [3:0] SEL_ESP_WR = 4'd1;
   localparam logic [3:0] SEL_EBP_WR = 4'd2;
   localparam logic [3:0] SEL_IMM    = 4'd3;
   localparam logic [3:0] SEL_PUSH   = 4'd4;
   localparam logic [3:0] SEL_POP    = 4'd5;
   localparam logic [3:0] SEL_EIP_WR = 4'd6;

   localparam logic [31:0] EIP_RESET  = 32'h0000_0000;
   localparam logic [31:0] EBP_RESET  = 32'h0000_0000;
   localparam logic [31:0] ESP_RESET  = 32'h0000_0FFC;
   localparam logic [31:0] STACK_STEP = 32'd4;

   localparam int TIMEOUT = 16;
   localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_P1   = 1'b1
   } state_e;

   typedef struct packed {
      logic eip_wr;
      logic esp_pop;
      logic esp_push;
      logic ebp_wr;
      logic esp_wr;
   } wr_en_t;

endpackage

// File: rtl/registor_select_decode.sv
// Maps a 4-bit destination code to one-hot register write enables.
// Codes 0, 3 and 7-15 produce no enable.
module registor_select_decode
   import registor_pkg::*;
(
   input  logic [3:0] sel,
   output wr_en_t     wr_en
);

   always_comb begin
      wr_en = '0;
      case (sel)
         SEL_ESP_WR: wr_en.esp_wr   = 1'b1;
         SEL_EBP_WR: wr_en.ebp_wr   = 1'b1;
         SEL_PUSH:   wr_en.esp_push = 1'b1;
         SEL_POP:    wr_en.esp_pop  = 1'b1;
         SEL_EIP_WR: wr_en.eip_wr   = 1'b1;
         default:    wr_en = '0;
      endcase
   end

endmodule

// File: rtl/registor_writer.sv
// Two-phase register write-back (eip/ebp/esp) with protocol-error tracking; writes land one cycle after the strobe.
// EIP_AUTO_INC_EN adds eip += eip_step on eip_step_valid (a code-6 write takes priority).
module registor_writer
   import registor_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        phase_1,
   input  logic        phase_2,
   input  logic [3:0]  select_1,
   input  logic [3:0]  select_2,
   input  logic [31:0] registor_input,
   input  logic        eip_step_valid,
   input  logic [3:0]  eip_step,
   output logic [31:0] eip,
   output logic [31:0] ebp,
   output logic [31:0] esp,
   output logic        busy,
   output logic        error
);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        error_q, error_d;
   logic [31:0] eip_q, eip_d;
   logic [31:0] ebp_q, ebp_d;
   logic [31:0] esp_q, esp_d;

   wr_en_t en_1, en_2, en;

   registor_select_decode u_dec_1 (.sel(select_1), .wr_en(en_1));
   registor_select_decode u_dec_2 (.sel(select_2), .wr_en(en_2));

`ifndef EIP_AUTO_INC_EN
   logic unused_step;
   assign unused_step = ^{eip_step_valid, eip_step};
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      error_d = error_q;
      en      = '0;
      case (state_q)
         ST_IDLE: begin
            if (phase_1) begin
               en      = en_1;
               state_d = ST_P1;
               cnt_d   = '0;
               if (phase_2) error_d = 1'b1;
            end else if (phase_2) begin
               error_d = 1'b1;
            end
         end
         ST_P1: begin
            // A second phase_1 (with or without phase_2) re-opens the transaction.
            if (phase_1) begin
               en      = en_1;
               cnt_d   = '0;
               error_d = 1'b1;
            end else if (phase_2) begin
               en      = en_2;
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      eip_d = eip_q;
      ebp_d = ebp_q;
      esp_d = esp_q;
`ifdef EIP_AUTO_INC_EN
      if (eip_step_valid) eip_d = eip_q + {28'd0, eip_step};
`endif
      if (en.eip_wr) eip_d = registor_input;
      if (en.ebp_wr) ebp_d = registor_input;
      if (en.esp_wr)
         esp_d = registor_input;
      else if (en.esp_push)
         esp_d = esp_q - STACK_STEP;
      else if (en.esp_pop)
         esp_d = esp_q + STACK_STEP;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         error_q <= 1'b0;
         eip_q   <= EIP_RESET;
         ebp_q   <= EBP_RESET;
         esp_q   <= ESP_RESET;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         error_q <= error_d;
         eip_q   <= eip_d;
         ebp_q   <= ebp_d;
         esp_q   <= esp_d;
      end
   end

   assign eip   = eip_q;
   assign ebp   = ebp_q;
   assign esp   = esp_q;
   assign busy  = (state_q == ST_P1);
   assign error = error_q;

endmodule
